float_sub_seq: RTL and testbench

- Multi-cycle IEEE-754 half-precision subtractor; computes res = float_a - float_b.
- It is the inverse-direction companion to the combinational float_add.
- It uses an iterative alignment shifter, an iterative normalizer and round-to-nearest-even.
- Valid/ready handshakes on both sides, so it can sit between operand FIFOs and a result consumer in the FP datapath.

---
 rtl/float_sub_seq.sv | 242 ++++++++++++++++++++++++
 tb/tb_float_sub_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/float_sub_seq.sv
// rtl/float_sub_seq.sv - multi-cycle half-precision subtractor, res = float_a - float_b
module float_sub_seq #(
    parameter int float_width    = 16,
    parameter int mantissa_width = 10,
    parameter int exponent_width = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [float_width-1:0] float_a,
    input  logic [float_width-1:0] float_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [float_width-1:0] res,
    output logic                   invalid,
    output logic                   overflow
);
    localparam int MW = mantissa_width;
    localparam int EW = exponent_width;
    localparam int SW = MW + 4;  // hidden, fraction, G, R, S

    localparam logic [EW-1:0]          EXP_MAX = '1;
    localparam logic [EW:0]            E_ONE   = {{EW{1'b0}}, 1'b1};
    localparam logic [EW:0]            E_INF   = {1'b0, EXP_MAX};
    localparam logic [EW-1:0]          D_ONE   = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0]          D_LIMIT = EW'(SW - 1);
    localparam logic [float_width-1:0] QNAN    = {1'b0, EXP_MAX, 1'b1, {(MW-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;

    state_t                 state_q, state_d;
    logic [float_width-1:0] a_q, a_d, b_q, b_d;
    logic                   sign_q, sign_d;
    logic                   eff_sub_q, eff_sub_d;
    logic                   special_q, special_d;
    logic [EW:0]            exp_q, exp_d;
    logic [EW-1:0]          d_q, d_d;
    logic [SW-1:0]          ma_q, ma_d, mb_q, mb_d;
    logic [SW:0]            sum_q, sum_d;
    logic [float_width-1:0] res_q, res_d;
    logic                   invalid_q, invalid_d;
    logic                   overflow_q, overflow_d;

    // Operand fields; the subtrahend's sign is flipped so the rest is an addition.
    logic             sa, sb;
    logic [EW-1:0]    ea, eb;
    logic [MW-1:0]    fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap, small_zero;
    logic [EW+MW-1:0] mag_a, mag_b;
    logic [SW-1:0]    sig_a, sig_b;

    assign sa     = a_q[float_width-1];
    assign sb     = ~b_q[float_width-1];
    assign ea     = a_q[EW+MW-1:MW];
    assign eb     = b_q[EW+MW-1:MW];
    assign fa     = a_q[MW-1:0];
    assign fb     = b_q[MW-1:0];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_MAX) && (fa == '0);
    assign b_inf  = (eb == EXP_MAX) && (fb == '0);
    assign a_nan  = (ea == EXP_MAX) && (fa != '0);
    assign b_nan  = (eb == EXP_MAX) && (fb != '0);
    // Subnormals count as zero, so their fraction must not influence the swap.
    assign mag_a  = a_zero ? '0 : a_q[EW+MW-1:0];
    assign mag_b  = b_zero ? '0 : b_q[EW+MW-1:0];
    assign sig_a  = a_zero ? '0 : {1'b1, fa, 3'b000};
    assign sig_b  = b_zero ? '0 : {1'b1, fb, 3'b000};
    assign swap   = (mag_b > mag_a);
    assign small_zero = swap ? a_zero : b_zero;

    // Magnitude add/subtract; A >= B after alignment, so the subtract never wraps.
    logic [SW:0] add_sum;
    assign add_sum = eff_sub_q ? ({1'b0, ma_q} - {1'b0, mb_q})
                               : ({1'b0, ma_q} + {1'b0, mb_q});

    // Round to nearest even on the normalized significand.
    logic          round_up;
    logic [MW+1:0] rnd;
    logic [EW:0]   rnd_exp;
    logic [MW-1:0] rnd_frac;
    assign round_up = sum_q[2] && (sum_q[1] || sum_q[0] || sum_q[3]);
    assign rnd      = {1'b0, sum_q[SW-1:3]} + {{(MW+1){1'b0}}, round_up};
    assign rnd_exp  = rnd[MW+1] ? exp_q + E_ONE : exp_q;
    assign rnd_frac = rnd[MW+1] ? rnd[MW:1] : rnd[MW-1:0];

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign res       = res_q;
    assign invalid   = invalid_q;
    assign overflow  = overflow_q;

    // Next-state and datapath updates for each step of the operation.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sign_d     = sign_q;
        eff_sub_d  = eff_sub_q;
        special_d  = special_q;
        exp_d      = exp_q;
        d_d        = d_q;
        ma_d       = ma_q;
        mb_d       = mb_q;
        sum_d      = sum_q;
        res_d      = res_q;
        invalid_d  = invalid_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = float_a;
                    b_d        = float_b;
                    invalid_d  = 1'b0;
                    overflow_d = 1'b0;
                    state_d    = UNPACK;
                end
            end
            UNPACK: begin
                special_d = 1'b1;
                if (a_nan || b_nan) begin
                    res_d     = QNAN;
                    invalid_d = 1'b1;
                end else if (a_inf && b_inf) begin
                    if (sa == sb) begin
                        res_d = {sa, EXP_MAX, {MW{1'b0}}};
                    end else begin
                        res_d     = QNAN;
                        invalid_d = 1'b1;
                    end
                end else if (a_inf) begin
                    res_d = {sa, EXP_MAX, {MW{1'b0}}};
                end else if (b_inf) begin
                    res_d = {sb, EXP_MAX, {MW{1'b0}}};
                end else begin
                    special_d = 1'b0;
                end
                if (special_d) begin
                    // Specials skip the arithmetic and leave through the ROUND slot untouched.
                    state_d = ROUND;
                end else begin
                    sign_d    = swap ? sb : sa;
                    eff_sub_d = sa ^ sb;
                    exp_d     = {1'b0, swap ? eb : ea};
                    ma_d      = swap ? sig_b : sig_a;
                    mb_d      = swap ? sig_a : sig_b;
                    d_d       = small_zero ? '0 : (swap ? (eb - ea) : (ea - eb));
                    state_d   = (small_zero || ea == eb) ? ADD : ALIGN;
                end
            end
            ALIGN: begin
                if (d_q > D_LIMIT) begin
                    mb_d    = {{(SW-1){1'b0}}, |mb_q};
                    d_d     = '0;
                    state_d = ADD;
                end else begin
                    mb_d = {1'b0, mb_q[SW-1:2], mb_q[1] | mb_q[0]};
                    d_d  = d_q - D_ONE;
                    if (d_q == D_ONE) begin
                        state_d = ADD;
                    end
                end
            end
            ADD: begin
                sum_d   = add_sum;
                state_d = (add_sum[SW] || !add_sum[SW-1]) ? NORM : ROUND;
            end
            NORM: begin
                if (sum_q == '0) begin
                    res_d   = '0;
                    state_d = DONE;
                end else if (sum_q[SW]) begin
                    sum_d   = {1'b0, sum_q[SW:2], sum_q[1] | sum_q[0]};
                    exp_d   = exp_q + E_ONE;
                    state_d = ROUND;
                end else if (exp_q <= E_ONE) begin
                    res_d   = {sign_q, {(float_width-1){1'b0}}};
                    state_d = DONE;
                end else begin
                    sum_d = {sum_q[SW-1:0], 1'b0};
                    exp_d = exp_q - E_ONE;
                    if (sum_q[SW-2]) begin
                        state_d = ROUND;
                    end
                end
            end
            ROUND: begin
                if (!special_q) begin
                    if (rnd_exp >= E_INF) begin
                        res_d      = {sign_q, EXP_MAX, {MW{1'b0}}};
                        overflow_d = 1'b1;
                    end else begin
                        res_d = {sign_q, rnd_exp[EW-1:0], rnd_frac};
                    end
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sign_q     <= 1'b0;
            eff_sub_q  <= 1'b0;
            special_q  <= 1'b0;
            exp_q      <= '0;
            d_q        <= '0;
            ma_q       <= '0;
            mb_q       <= '0;
            sum_q      <= '0;
            res_q      <= '0;
            invalid_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sign_q     <= sign_d;
            eff_sub_q  <= eff_sub_d;
            special_q  <= special_d;
            exp_q      <= exp_d;
            d_q        <= d_d;
            ma_q       <= ma_d;
            mb_q       <= mb_d;
            sum_q      <= sum_d;
            res_q      <= res_d;
            invalid_q  <= invalid_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_float_sub_seq.sv
// tb/tb_float_sub_seq.sv - scoreboard bench for float_sub_seq against an exact-arithmetic model
module tb_float_sub_seq;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, invalid, overflow;
    logic [15:0] float_a, float_b, res;

    float_sub_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .float_a(float_a), .float_b(float_b), .out_valid(out_valid),
        .out_ready(out_ready), .res(res), .invalid(invalid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] res;
        logic        inv;
        logic        ovf;
        int          lat;
        int          hold;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Value of a half in units of 2^-24; subnormals read as zero.
    function automatic longint half_val(input logic [15:0] x);
        longint v;
        if (x[14:10] == 5'd0) return 0;
        v = longint'(1024 + int'(x[9:0])) << (int'(x[14:10]) - 1);
        return x[15] ? -v : v;
    endfunction

    // Reference: exact difference, then round-to-nearest-even into half precision.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t   e;
        longint diff, mag, q, rem, half;
        int     p, shift, ex;
        logic   s;
        logic   a_nan, b_nan, a_inf, b_inf;
        e.lat = -1; e.hold = 0; e.acc = 0; e.inv = 1'b0; e.ovf = 1'b0; e.res = 16'h0000;
        a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 0);
        b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 0);
        a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 0);
        b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 0);
        if (a_nan || b_nan || (a_inf && b_inf && a[15] == b[15])) begin
            e.res = 16'h7E00; e.inv = 1'b1; return e;
        end
        if (a_inf) begin e.res = {a[15], 15'h7C00}; return e; end
        if (b_inf) begin e.res = {~b[15], 15'h7C00}; return e; end
        diff = half_val(a) - half_val(b);
        if (diff == 0) return e;
        s = (diff < 0);
        mag = s ? -diff : diff;
        p = 0;
        for (int i = 0; i < 62; i++) if (mag[i]) p = i;
        ex = p - 9;
        if (ex < 1) begin e.res = {s, 15'h0000}; return e; end
        shift = p - 10;
        q = mag >> shift;
        if (shift > 0) begin
            rem  = mag - (q << shift);
            half = longint'(1) << (shift - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
        end
        if (q == 2048) begin q = 1024; ex = ex + 1; end
        if (ex >= 31) begin
            e.res = {s, 15'h7C00}; e.ovf = 1'b1;
        end else begin
            e.res = {s, ex[4:0], q[9:0]};
        end
        return e;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || in_ready !== 1'b1) && n < 400) begin
            @(negedge clk); n++;
        end
        if (n >= 400) begin
            checks++; failures++;
            $display("FAIL idle_timeout: in_ready=%b outstanding=%0d required idle", in_ready, sb.size());
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input int lat, input int hold);
        exp_t e;
        wait_idle();
        float_a = a; float_b = b; in_valid = 1'b1;
        e = model(a, b);
        e.lat = lat; e.hold = hold;
        @(posedge clk); #1;
        in_valid = 1'b0;
        float_a = 16'($urandom); float_b = 16'($urandom);
        e.acc = cyc;
        sb.push_back(e);
    endtask

    function automatic logic [15:0] rand_half(input int elo, input int ehi);
        logic [4:0] ex;
        ex = 5'($urandom_range(elo, ehi));
        return {1'($urandom), ex, 10'($urandom)};
    endfunction

    // Monitor: pops one expectation per presented result, checks it, then consumes it.
    initial begin : monitor
        exp_t e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL spurious_out_valid: got res=%h with nothing outstanding", res);
                    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
                end else begin
                    e = sb.pop_front();
                    if (e.lat >= 0) check("latency", cyc - e.acc, e.lat);
                    check("res", res, e.res);
                    check("invalid", invalid, e.inv);
                    check("overflow", overflow, e.ovf);
                    for (int h = 0; h < e.hold; h++) begin
                        @(negedge clk);
                        check("hold_valid", out_valid, 1);
                        check("hold_res", res, e.res);
                    end
                    out_ready = 1'b1;
                    @(posedge clk); #1;
                    out_ready = 1'b0;
                    check("valid_dropped", out_valid, 0);
                    check("ready_after", in_ready, 1);
                end
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [15:0] ra, rb;
        int mode, e2;
        rst = 1'b1; in_valid = 1'b0; float_a = '0; float_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_res", res, 0);
        check("reset_invalid", invalid, 0);
        check("reset_overflow", overflow, 0);
        @(negedge clk); rst = 1'b0;

        issue(16'h34CD, 16'h3266, 6, 0);
        issue(16'h34CD, 16'h34CD, 3, 5);
        issue(16'h34CD, 16'hB4CD, 4, 0);
        issue(16'h3C00, 16'h3111, 7, 0);
        issue(16'h3C00, 16'h0001, 3, 0);
        issue(16'h7C00, 16'h7C00, 2, 0);
        issue(16'h7C00, 16'hFC00, 2, 0);
        issue(16'h7E00, 16'h3C00, 2, 1);
        issue(16'h7BFF, 16'hFBFF, 4, 0);
        issue(16'h3C00, 16'h0400, 5, 0);
        issue(16'h3C00, 16'h1000, 15, 0);

        // Reset in the middle of a long alignment.
        wait_idle();
        float_a = 16'h3C00; float_b = 16'h3111; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_in_ready", in_ready, 0);
        @(posedge clk); #2;
        rst = 1'b1; #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_res", res, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk); rst = 1'b0;
        issue(16'h34CD, 16'h3266, 6, 0);

        for (int i = 0; i < 400; i++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: begin ra = 16'($urandom); rb = 16'($urandom); end
                1: begin
                    ra = rand_half(1, 30);
                    e2 = int'(ra[14:10]) + int'($urandom_range(0, 4)) - 2;
                    if (e2 < 1) e2 = 1;
                    if (e2 > 30) e2 = 30;
                    rb = rand_half(e2, e2);
                end
                2: begin
                    ra = rand_half(1, 30);
                    rb = {ra[15], ra[14:0] ^ 15'($urandom_range(0, 15))};
                end
                default: begin
                    ra = rand_half(28, 30);
                    rb = rand_half(28, 30);
                end
            endcase
            issue(ra, rb, -1, int'($urandom_range(0, 2)));
        end

        wait_idle();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
